// File: rtl/uart_param.sv
// Parametrised full-duplex UART: configurable width, baud divider, parity and stop bits,
// with parity/framing error flags. Define UART_RX_FIFO_EN to buffer received words in a FIFO.
`timescale 1ns/1ps
module uart_param #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 transmit,
    input  logic [DATA_BITS-1:0] data_tx,
    output logic                 busy_tx,
    output logic                 tx,
    input  logic                 rx,
    output logic                 busy_rx,
    output logic                 recieved,
    output logic [DATA_BITS-1:0] data_rx,
    input  logic                 rx_pop,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BIT_HALF   = 16'(CLKS_PER_BIT / 2);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST  = (STOP_BITS == 2);
    localparam logic        HAS_PARITY = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 tx_state_q, tx_state_d;
    logic [15:0]            tx_timer_q, tx_timer_d;
    logic [3:0]             tx_bit_q, tx_bit_d;
    logic                   tx_stop_q, tx_stop_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_q, tx_d;
    logic                   tx_tick, tx_load;

    assign tx_tick = (tx_timer_q == BIT_LAST);
    // A new word is taken in IDLE, or straight out of the last stop bit so held requests chain without a gap.
    assign tx_load = transmit && ((tx_state_q == S_IDLE) ||
                     (tx_state_q == S_STOP && tx_tick && tx_stop_q == STOP_LAST));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_tick ? 16'd0 : tx_timer_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_stop_d  = tx_stop_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        case (tx_state_q)
            S_IDLE: begin
                tx_timer_d = 16'd0;
                tx_d       = 1'b1;
            end
            S_START: begin
                if (tx_tick) begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = 4'd0;
                    tx_d       = tx_shift_q[0];
                end
            end
            S_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_stop_d = 1'b0;
                        if (HAS_PARITY) begin
                            tx_state_d = S_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = S_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = S_STOP;
                    tx_stop_d  = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            S_STOP: begin
                if (tx_tick) begin
                    if (tx_stop_q == STOP_LAST) tx_state_d = S_IDLE;
                    else tx_stop_d = 1'b1;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_state_d = S_START;
            tx_timer_d = 16'd0;
            tx_shift_d = data_tx;
            tx_par_d   = (PARITY == 1) ? ~^data_tx : ^data_tx;
            tx_d       = 1'b0;
        end
    end

    assign busy_tx = (tx_state_q != S_IDLE);
    assign tx      = tx_q;

    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
    state_t                 rx_state_q, rx_state_d;
    logic [15:0]            rx_timer_q, rx_timer_d;
    logic [3:0]             rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_par_q, rx_par_d;
    logic                   rx_done_q, rx_done_d;
    logic [DATA_BITS-1:0]   rx_word_q, rx_word_d;
    logic                   rx_pe_q, rx_pe_d;
    logic                   rx_fe_q, rx_fe_d;
    logic                   rx_tick, rx_mid, rx_fall;

    assign rx_tick = (rx_timer_q == BIT_LAST);
    assign rx_mid  = (rx_timer_q == BIT_HALF);
    assign rx_fall = rx_prev_q && !rx_sync_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_timer_d = rx_tick ? 16'd0 : rx_timer_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_done_d  = 1'b0;
        rx_word_d  = rx_word_q;
        rx_pe_d    = rx_pe_q;
        rx_fe_d    = rx_fe_q;
        case (rx_state_q)
            S_IDLE: begin
                rx_timer_d = 16'd0;
                if (rx_fall) rx_state_d = S_START;
            end
            S_START: begin
                // Re-zeroing at mid start bit puts every later sample at mid-bit.
                if (rx_mid) begin
                    rx_timer_d = 16'd0;
                    rx_bit_d   = 4'd0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PARITY ? S_PARITY : S_STOP;
                    else rx_bit_d = rx_bit_q + 4'd1;
                end
            end
            S_PARITY: begin
                if (rx_tick) begin
                    rx_par_d   = rx_sync_q;
                    rx_state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_tick) begin
                    rx_state_d = S_IDLE;
                    rx_done_d  = 1'b1;
                    rx_word_d  = rx_shift_q;
                    rx_fe_d    = !rx_sync_q;
                    rx_pe_d    = HAS_PARITY &&
                                 (rx_par_q != ((PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q));
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    assign busy_rx = (rx_state_q != S_IDLE);

`ifdef UART_RX_FIFO_EN
    localparam int AW = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(RX_FIFO_DEPTH);

    logic [DATA_BITS-1:0]     mem_data_q [RX_FIFO_DEPTH];
    logic [DATA_BITS-1:0]     mem_data_d [RX_FIFO_DEPTH];
    logic [RX_FIFO_DEPTH-1:0] mem_pe_q, mem_pe_d, mem_fe_q, mem_fe_d;
    logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_ovf;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_FULL);
    assign fifo_pop   = rx_pop && !fifo_empty;
    assign fifo_push  = rx_done_q && (!fifo_full || fifo_pop);
    // Overflow drops the new word and marks the head so the loss is visible to the reader.
    assign fifo_ovf   = rx_done_q && fifo_full && !fifo_pop;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_pe_d   = mem_pe_q;
        mem_fe_d   = mem_fe_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        if (fifo_push) begin
            mem_data_d[wr_q] = rx_word_q;
            mem_pe_d[wr_q]   = rx_pe_q;
            mem_fe_d[wr_q]   = rx_fe_q;
            wr_d             = wr_q + PTR_ONE;
        end
        if (fifo_pop) rd_d = rd_q + PTR_ONE;
        if (fifo_ovf) mem_fe_d[rd_q] = 1'b1;
        case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            mem_data_q <= '{default: '0};
            mem_pe_q   <= '0;
            mem_fe_q   <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            mem_pe_q   <= mem_pe_d;
            mem_fe_q   <= mem_fe_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign recieved   = !fifo_empty;
    assign data_rx    = mem_data_q[rd_q];
    assign parity_err = mem_pe_q[rd_q];
    assign frame_err  = mem_fe_q[rd_q];
`else
    logic unused_rx_pop;
    assign unused_rx_pop = rx_pop & (RX_FIFO_DEPTH > 0);

    assign recieved   = rx_done_q;
    assign data_rx    = rx_word_q;
    assign parity_err = rx_pe_q;
    assign frame_err  = rx_fe_q;
`endif

    always_ff @(posedge clk) begin
        if (!nRst) begin
            tx_state_q <= S_IDLE;
            tx_timer_q <= '0;
            tx_bit_q   <= '0;
            tx_stop_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_timer_q <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_done_q  <= 1'b0;
            rx_word_q  <= '0;
            rx_pe_q    <= 1'b0;
            rx_fe_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_bit_q   <= tx_bit_d;
            tx_stop_q  <= tx_stop_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_done_q  <= rx_done_d;
            rx_word_q  <= rx_word_d;
            rx_pe_q    <= rx_pe_d;
            rx_fe_q    <= rx_fe_d;
        end
    end
endmodule

// File: tb/tb_uart_param.sv
// Directed bench for uart_param: an 8E1 instance (loopback or injected rx) and a 9N2 loopback instance.
`timescale 1ns/1ps
module tb_uart_param;
    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nRst;
    logic       transmit, rx_drv, rx_sel, auto_pop, rx_a;
    logic       rx_pop = 1'b0;
    logic [7:0] data_tx, data_rx;
    logic       busy_tx, tx, busy_rx, recieved, parity_err, frame_err;

    logic       transmit9, busy_tx9, tx9, busy_rx9, recieved9, pe9, fe9;
    logic       rx_pop9 = 1'b0;
    logic [8:0] data_tx9, data_rx9;

    assign rx_a = rx_sel ? rx_drv : tx;

    uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .RX_FIFO_DEPTH(4)) dut (
        .clk(clk), .nRst(nRst), .transmit(transmit), .data_tx(data_tx), .busy_tx(busy_tx), .tx(tx),
        .rx(rx_a), .busy_rx(busy_rx), .recieved(recieved), .data_rx(data_rx), .rx_pop(rx_pop),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .RX_FIFO_DEPTH(4)) dut9 (
        .clk(clk), .nRst(nRst), .transmit(transmit9), .data_tx(data_tx9), .busy_tx(busy_tx9), .tx(tx9),
        .rx(tx9), .busy_rx(busy_rx9), .recieved(recieved9), .data_rx(data_rx9), .rx_pop(rx_pop9),
        .parity_err(pe9), .frame_err(fe9)
    );

    // Scoreboard entries are {frame_err, parity_err, data}.
    logic [9:0]  exp_q[$];
    logic [9:0]  got_q[$];
    logic [10:0] got9_q[$];
    int errors = 0;
    int checks = 0;

    // {expected even parity, word}, parity worked out by hand.
    logic [8:0] lb_vec [8] = '{9'h05A, 9'h000, 9'h0FF, 9'h101, 9'h180, 9'h0A5, 9'h03C, 9'h17F};
    logic [7:0] fifo_w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    always @(negedge clk) begin
        if (nRst && recieved && auto_pop) begin
            got_q.push_back({frame_err, parity_err, data_rx});
            rx_pop = 1'b1;
        end else begin
            rx_pop = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (nRst && recieved9) begin
            got9_q.push_back({fe9, pe9, data_rx9});
            rx_pop9 = 1'b1;
        end else begin
            rx_pop9 = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d of %0d errors so far", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            step(CPB);
        end
        rx_drv = 1'b1;
    endtask

    task automatic sb_drain(input string tag);
        logic [9:0] e, g;
        for (int k = 0; k < 200 && got_q.size() < exp_q.size(); k++) step(1);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check(tag, {22'd0, g}, {22'd0, e});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [8:0] cur;
        int zeros, cnt;
        logic s_b0, s_b7, s_par, s_stop, saw_busy;

        nRst = 1'b0; transmit = 1'b0; data_tx = 8'h00; transmit9 = 1'b0; data_tx9 = 9'h000;
        rx_drv = 1'b1; rx_sel = 1'b0; auto_pop = 1'b1;
        step(3);
        check("rst_tx", tx, 1);
        check("rst_busy_tx", busy_tx, 0);
        check("rst_busy_rx", busy_rx, 0);
        check("rst_recieved", recieved, 0);
        check("rst_data_rx", data_rx, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_tx9", tx9, 1);
        nRst = 1'b1;
        step(4);

        // Back-to-back 8E1 loopback with transmit held high; each frame is 11*16 cycles.
        transmit = 1'b1;
        data_tx  = lb_vec[0][7:0];
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            cur = lb_vec[i];
            exp_q.push_back({2'b00, cur[7:0]});
            if (i < 7) data_tx = lb_vec[i+1][7:0];
            else transmit = 1'b0;
            zeros = 0;
            s_b0 = 1'b0; s_b7 = 1'b0; s_par = 1'b0; s_stop = 1'b0;
            for (int k = 0; k < 176; k++) begin
                if (k < 16 && tx === 1'b0) zeros++;
                if (k == 16)  s_b0   = tx;
                if (k == 136) s_b7   = tx;
                if (k == 152) s_par  = tx;
                if (k == 168) s_stop = tx;
                if (k < 175) step(1);
            end
            check("tx_start_len", 32'(zeros), 16);
            check("tx_bit0", s_b0, {31'd0, cur[0]});
            check("tx_bit7", s_b7, {31'd0, cur[7]});
            check("tx_parity", s_par, {31'd0, cur[8]});
            check("tx_stop", s_stop, 1);
        end
        check("busy_tx_last_stop", busy_tx, 1);
        step(1);
        check("busy_tx_after_stop", busy_tx, 0);
        sb_drain("loopback");

        // Injected frames: bad parity, stop bit low, then a clean frame.
        rx_sel = 1'b1;
        step(4);
        drive_bits({5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11);
        exp_q.push_back({1'b0, 1'b1, 8'h5A});
        step(4);
        drive_bits({5'b0, 1'b0, 1'b0, 8'h3C, 1'b0}, 11);
        exp_q.push_back({1'b1, 1'b0, 8'h3C});
        step(4);
        drive_bits({5'b0, 1'b1, 1'b1, 8'h3D, 1'b0}, 11);
        exp_q.push_back({1'b0, 1'b0, 8'h3D});
        step(4);
        sb_drain("inject");

        // Short low glitch: receiver wakes, rejects it at mid start bit.
        saw_busy = 1'b0;
        rx_drv = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) rx_drv = 1'b1;
            if (busy_rx === 1'b1) saw_busy = 1'b1;
            step(1);
        end
        check("glitch_busy_rose", saw_busy, 1);
        check("glitch_busy_fell", busy_rx, 0);
        check("glitch_no_word", 32'(got_q.size()), 0);
        check("glitch_recieved", recieved, 0);

        // 9N2: 12-bit frame, busy_tx for 12*16 cycles.
        data_tx9  = 9'h1A5;
        transmit9 = 1'b1;
        step(1);
        transmit9 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 400; k++) begin
            if (busy_tx9 !== 1'b1) break;
            cnt++;
            step(1);
        end
        check("tx9_busy_len", 32'(cnt), 192);
        check("tx9_idle", tx9, 1);
        for (int k = 0; k < 100 && got9_q.size() == 0; k++) step(1);
        check("rx9_count", 32'(got9_q.size()), 1);
        if (got9_q.size() > 0) check("rx9_word", {21'd0, got9_q.pop_front()}, {21'd0, 2'b00, 9'h1A5});

`ifdef UART_RX_FIFO_EN
        // Five words into a four-deep FIFO with nobody popping.
        auto_pop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_bits({5'b0, 1'b1, 1'b0, fifo_w[i], 1'b0}, 11);
            step(4);
        end
        step(8);
        check("fifo_recieved", recieved, 1);
        check("fifo_head_data", data_rx, 8'h11);
        check("fifo_head_fe", frame_err, 1);
        check("fifo_head_pe", parity_err, 0);
        exp_q.push_back({1'b1, 1'b0, 8'h11});
        exp_q.push_back({1'b0, 1'b0, 8'h22});
        exp_q.push_back({1'b0, 1'b0, 8'h33});
        exp_q.push_back({1'b0, 1'b0, 8'h44});
        auto_pop = 1'b1;
        step(10);
        sb_drain("fifo_pop");
        check("fifo_empty", recieved, 0);
`endif

        // Reset in the middle of a 9N2 frame.
        data_tx9  = 9'h0F0;
        transmit9 = 1'b1;
        step(1);
        transmit9 = 1'b0;
        step(50);
        check("pre_reset_busy_tx9", busy_tx9, 1);
        nRst = 1'b0;
        step(1);
        check("midreset_tx9", tx9, 1);
        check("midreset_busy_tx9", busy_tx9, 0);
        check("midreset_busy_rx9", busy_rx9, 0);
        nRst = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
